// File: rtl/np_serial_adder_pkg.sv
// np_serial_adder shared types.
// FSM encoding and digit-count helper.
package np_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int digits(int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/np_serial_adder_if.sv
// np_serial_adder operand/result handshake bundle.
// slave is the adder side, master the producer/consumer side.
interface np_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, co
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, co
  );
endinterface

// File: rtl/np_2bit_adder_ci.sv
// np_2bit_adder_ci: 2-bit adder with carry-in.
// {co,s} = a + b + ci, sum-of-products form.
module np_2bit_adder_ci (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);
  logic c0;

  assign s[0] = a[0] ^ b[0] ^ ci;
  assign c0   = (a[0] & b[0]) | (a[0] & ci) | (b[0] & ci);
  assign s[1] = a[1] ^ b[1] ^ c0;
  assign co   = (a[1] & b[1]) | (a[1] & c0) | (b[1] & c0);
endmodule

// File: rtl/np_serial_adder.sv
// np_serial_adder: digit-serial adder, 2 bits per clock.
// LSB digit first, registered carry between digits.
module np_serial_adder
  import np_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  np_serial_adder_if.slave bus
);
  localparam int DIGITS = digits(WIDTH);
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             c_q, co_q;
  logic [1:0]       d;
  logic             c_n;
  logic [WIDTH-1:0] s_sh;
  logic             last;
  logic             in_rdy, out_vld;
  logic             accept;

  np_2bit_adder_ci u_add (
    .a  (a_q[1:0]),
    .b  (b_q[1:0]),
    .ci (c_q),
    .s  (d),
    .co (c_n)
  );

  // New digit enters at the MSB end; after DIGITS steps the sum is aligned.
  if (WIDTH == 2) begin : g_sh2
    assign s_sh = d;
  end else begin : g_shn
    assign s_sh = {d, s_q[WIDTH-1:2]};
  end

  assign last   = (cnt_q == CW'(DIGITS - 1));
  assign accept = (state_q == IDLE) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      co_q  <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      c_q   <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> 2;
      b_q   <= b_q >> 2;
      s_q   <= s_sh;
      c_q   <= c_n;
      cnt_q <= cnt_q + CW'(1);
      if (last) co_q <= c_n;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.sum       = s_q;
  assign bus.co        = co_q;
endmodule

// File: tb/tb_np_serial_adder.sv
// tb_np_serial_adder: directed + random checks of np_serial_adder
// against plain a+b arithmetic, WIDTH=8 and WIDTH=2 instances.
module tb_np_serial_adder;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  np_serial_adder_if #(.WIDTH(8)) bus8 ();
  np_serial_adder_if #(.WIDTH(2)) bus2 ();

  np_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  np_serial_adder #(.WIDTH(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] a,
                     input logic [7:0] b,
                     input int hold,
                     input bit noacc);
    logic [8:0] exp;
    int lat;
    exp = {1'b0, a} + {1'b0, b};
    chk("rdy8", 32'(bus8.in_ready), 32'd1);
    bus8.in_valid = 1'b1;
    bus8.a = a;
    bus8.b = b;
    tick;
    bus8.in_valid = 1'b0;
    bus8.a = 8'($urandom);
    bus8.b = 8'($urandom);
    chk("busy8", 32'(bus8.in_ready), 32'd0);
    lat = 0;
    while (!bus8.out_valid && lat < 20) begin
      tick;
      lat++;
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
    end
    chk("lat8", 32'(lat), 32'd4);
    chk("sum8", 32'(bus8.sum), 32'(exp[7:0]));
    chk("co8", 32'(bus8.co), 32'(exp[8]));
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_v8", 32'(bus8.out_valid), 32'd1);
      chk("hold_r8", 32'(bus8.in_ready), 32'd0);
      chk("hold_s8", 32'({bus8.co, bus8.sum}), 32'(exp));
    end
    bus8.out_ready = 1'b1;
    if (noacc) bus8.in_valid = 1'b1;
    tick;
    bus8.out_ready = 1'b0;
    bus8.in_valid = 1'b0;
    chk("idle_r8", 32'(bus8.in_ready), 32'd1);
    chk("idle_v8", 32'(bus8.out_valid), 32'd0);
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] exp;
    int lat;
    exp = {1'b0, a} + {1'b0, b};
    bus2.in_valid = 1'b1;
    bus2.a = a;
    bus2.b = b;
    tick;
    bus2.in_valid = 1'b0;
    bus2.a = 2'($urandom);
    bus2.b = 2'($urandom);
    lat = 0;
    while (!bus2.out_valid && lat < 10) begin
      tick;
      lat++;
    end
    chk("lat2", 32'(lat), 32'd1);
    chk("sum2", 32'({bus2.co, bus2.sum}), 32'(exp));
    bus2.out_ready = 1'b1;
    tick;
    bus2.out_ready = 1'b0;
    chk("idle_r2", 32'(bus2.in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b0;
    bus2.a = '0;
    bus2.b = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_rdy", 32'(bus8.in_ready), 32'd1);
    chk("rst_vld", 32'(bus8.out_valid), 32'd0);
    chk("rst_sum", 32'(bus8.sum), 32'd0);
    chk("rst_co", 32'(bus8.co), 32'd0);
    chk("rst_rdy2", 32'(bus2.in_ready), 32'd1);

    op8(8'h5A, 8'h3C, 3, 1'b0);
    op8(8'hFF, 8'h01, 0, 1'b0);
    op8(8'hFF, 8'hFF, 1, 1'b1);
    op8(8'h81, 8'h81, 0, 1'b0);

    // Abort an operation mid-flight.
    bus8.in_valid = 1'b1;
    bus8.a = 8'h12;
    bus8.b = 8'h34;
    tick;
    bus8.in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_rdy", 32'(bus8.in_ready), 32'd1);
    chk("abort_vld", 32'(bus8.out_valid), 32'd0);
    chk("abort_sum", 32'(bus8.sum), 32'd0);
    chk("abort_co", 32'(bus8.co), 32'd0);
    op8(8'h01, 8'h02, 0, 1'b0);

    for (int i = 0; i < 40; i++)
      op8(8'($urandom), 8'($urandom),
          int'($urandom_range(0, 3)), 1'($urandom));

    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        op2(2'(x), 2'(y));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
